// File: rtl/updown_counter_pkg.sv
// Purpose : shared mode encodings for the up/down/bounce counter family.
// Latency : n/a (types and constants only).
// Backpressure : n/a.
//
// Contents:
//   mode_t      2-bit counting mode (up-wrap, down-wrap, bounce, hold)
//   MODE_W      width of the mode field
package updown_counter_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_UP     = 2'b00,  // count up, wrap hi -> lo
    MODE_DOWN   = 2'b01,  // count down, wrap lo -> hi
    MODE_BOUNCE = 2'b10,  // ping-pong between lo and hi
    MODE_HOLD   = 2'b11   // freeze value and direction
  } mode_t;

endpackage : updown_counter_pkg

// File: rtl/tick_gen.sv
// Purpose : prescaler issuing a one-cycle clock-enable strobe every DIV cycles,
//           DIV chosen at runtime between SLOW_DIV and FAST_DIV.
// Latency : first tick DIV cycles after reset release / enable / rate change.
// Backpressure : none; i_en=0 holds the count and the strobe at zero.
//
// Ports:
//   i_clk    system clock (only clock edge in the design)
//   i_rst    synchronous active-high reset
//   i_en     run enable; 0 clears the prescaler and suppresses o_tick
//   i_speed  0 = SLOW_DIV rate, 1 = FAST_DIV rate
//   o_tick   registered one-cycle step strobe
module tick_gen #(
  parameter int SLOW_DIV = 50_000_000,
  parameter int FAST_DIV = 12_500_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_speed,
  output logic o_tick
);

  // Sized for the slower (larger) divider; the fast one always fits.
  localparam int CW = $clog2(SLOW_DIV + 1);

  localparam logic [CW-1:0] SLOW_TOP = CW'(SLOW_DIV - 1);
  localparam logic [CW-1:0] FAST_TOP = CW'(FAST_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          r_speed_q;
  logic          r_tick;
  logic [CW-1:0] w_top;
  logic          w_rate_chg;

  // Terminal count follows the registered rate so a rate change is only
  // acted on after the restart cycle below.
  assign w_top      = r_speed_q ? FAST_TOP : SLOW_TOP;
  assign w_rate_chg = (i_speed != r_speed_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_speed_q <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_speed_q <= i_speed;
      if (!i_en || w_rate_chg) begin
        // Restart from zero on a rate change so the first period at the new
        // rate is a full one (no runt step); the strobe is withheld meanwhile.
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end else if (r_cnt == w_top) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CNT_ONE;
        r_tick <= 1'b0;
      end
    end
  end

  assign o_tick = r_tick;

endmodule : tick_gen

// File: rtl/updown_counter_gen.sv
// Purpose : WIDTH-bit up-wrap / down-wrap / bounce / hold counter between
//           runtime limits, with parallel load, paced by an internal prescaler.
// Latency : out/wrap update on the clock edge that ends a tick cycle; load
//           takes effect on the next edge.
// Backpressure : none; en=0 freezes counting, cfg_err suppresses steps.
//
// Ports:
//   i_clk, i_rst         system clock, synchronous active-high reset
//   i_en                 count enable (freezes out, dir and prescaler)
//   i_speed              prescaler rate select (0 slow, 1 fast)
//   i_mode               counting mode, see updown_counter_pkg::mode_t
//   i_load, i_load_val   parallel load strobe and value
//   i_lo, i_hi           inclusive count limits
//   o_out                counter value
//   o_dir                1 = counting up, 0 = counting down
//   o_tick               prescaler step strobe
//   o_wrap               one-cycle pulse on wrap or bounce reversal
//   o_cfg_err            combinational, 1 when lo > hi
module updown_counter_gen
  import updown_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SLOW_DIV = 50_000_000,
  parameter int FAST_DIV = 12_500_000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_speed,
  input  logic [MODE_W-1:0]  i_mode,
  input  logic               i_load,
  input  logic [WIDTH-1:0]   i_load_val,
  input  logic [WIDTH-1:0]   i_lo,
  input  logic [WIDTH-1:0]   i_hi,
  output logic [WIDTH-1:0]   o_out,
  output logic               o_dir,
  output logic               o_tick,
  output logic               o_wrap,
  output logic               o_cfg_err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_out;
  logic             r_dir;
  logic             r_wrap;

  logic             w_tick;
  logic             w_cfg_err;
  logic             w_step;
  logic             w_in_range;
  mode_t            w_mode;
  logic [WIDTH-1:0] w_nxt_out;
  logic             w_nxt_dir;
  logic             w_nxt_wrap;

  tick_gen #(
    .SLOW_DIV (SLOW_DIV),
    .FAST_DIV (FAST_DIV)
  ) u_tick_gen (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (i_en),
    .i_speed (i_speed),
    .o_tick  (w_tick)
  );

  assign w_mode     = mode_t'(i_mode);
  assign w_cfg_err  = (i_lo > i_hi);
  assign w_in_range = (r_out >= i_lo) && (r_out <= i_hi);
  assign w_step     = w_tick && i_en && !i_load && !w_cfg_err;

  // Next value for a step. Every wrap is steered by the limits, so the
  // +1/-1 below never crosses the natural WIDTH-bit boundary while limits
  // are consistent (the out-of-range cases are caught first).
  always_comb begin
    w_nxt_out  = r_out;
    w_nxt_dir  = r_dir;
    w_nxt_wrap = 1'b0;
    if ((w_mode != MODE_HOLD) && (i_lo == i_hi)) begin
      // Degenerate single-value range: pin to it, keep direction, no pulse.
      w_nxt_out = i_lo;
    end else begin
      case (w_mode)
        MODE_UP: begin
          w_nxt_dir = 1'b1;
          if ((r_out == i_hi) || !w_in_range) begin
            w_nxt_out  = i_lo;
            w_nxt_wrap = 1'b1;
          end else begin
            w_nxt_out = r_out + ONE;
          end
        end
        MODE_DOWN: begin
          w_nxt_dir = 1'b0;
          if ((r_out == i_lo) || !w_in_range) begin
            w_nxt_out  = i_hi;
            w_nxt_wrap = 1'b1;
          end else begin
            w_nxt_out = r_out - ONE;
          end
        end
        MODE_BOUNCE: begin
          if (!w_in_range) begin
            // Re-enter the range from the bottom, heading up; not a reversal.
            w_nxt_out = i_lo;
            w_nxt_dir = 1'b1;
          end else if (r_dir) begin
            if (r_out >= i_hi) begin
              // Endpoint is shown once: turn around straight to hi-1.
              w_nxt_out  = i_hi - ONE;
              w_nxt_dir  = 1'b0;
              w_nxt_wrap = 1'b1;
            end else begin
              w_nxt_out = r_out + ONE;
            end
          end else begin
            if (r_out <= i_lo) begin
              w_nxt_out  = i_lo + ONE;
              w_nxt_dir  = 1'b1;
              w_nxt_wrap = 1'b1;
            end else begin
              w_nxt_out = r_out - ONE;
            end
          end
        end
        MODE_HOLD: begin
          w_nxt_out = r_out;
        end
      endcase
    end
  end

  // Priority: reset, then load (which discards a coincident step), then step.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out  <= '0;
      r_dir  <= 1'b1;
      r_wrap <= 1'b0;
    end else if (i_load) begin
      r_out  <= i_load_val;
      r_wrap <= 1'b0;
    end else if (w_step) begin
      r_out  <= w_nxt_out;
      r_dir  <= w_nxt_dir;
      r_wrap <= w_nxt_wrap;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign o_out     = r_out;
  assign o_dir     = r_dir;
  assign o_tick    = w_tick;
  assign o_wrap    = r_wrap;
  assign o_cfg_err = w_cfg_err;

endmodule : updown_counter_gen

// File: tb/tb_updown_counter_gen.sv
// Purpose : directed self-checking bench for updown_counter_gen.
// Latency : n/a.
// Backpressure : n/a.
module tb_updown_counter_gen;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         speed;
  logic [1:0]   mode;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic [W-1:0] o_out;
  logic         o_dir;
  logic         o_tick;
  logic         o_wrap;
  logic         o_cfg_err;

  int errors = 0;
  int checks = 0;

  updown_counter_gen #(
    .WIDTH    (W),
    .SLOW_DIV (4),
    .FAST_DIV (2)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_speed    (speed),
    .i_mode     (mode),
    .i_load     (load),
    .i_load_val (load_val),
    .i_lo       (lo),
    .i_hi       (hi),
    .o_out      (o_out),
    .o_dir      (o_dir),
    .o_tick     (o_tick),
    .o_wrap     (o_wrap),
    .o_cfg_err  (o_cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until o_tick is seen high; cycles = edges advanced.
  task automatic wait_tick(output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_tick) begin
        ok = 1'b1;
        break;
      end
      cyc();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; speed = 1'b0; mode = 2'b10;
    load = 1'b0; load_val = '0; lo = 4'd0; hi = 4'd15;
    repeat (3) cyc();
    checks++; if (o_out !== 4'd0) begin errors++; $display("FAIL reset_out: got %0d want 0", o_out); end
    checks++; if (o_dir !== 1'b1) begin errors++; $display("FAIL reset_dir: got %b want 1", o_dir); end
    checks++; if (o_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", o_tick); end
    checks++; if (o_wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", o_wrap); end
    checks++; if (o_cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b want 0", o_cfg_err); end
  endtask

  task automatic test_bounce();
    bit ok; int c; int req;
    logic [W-1:0] eo; logic ed; logic ew;
    rst = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      wait_tick(ok, c);
      req = (k == 1) ? 4 : 3;
      checks++;
      if (!ok || c != req) begin
        errors++; $display("FAIL bounce_tick_spacing step %0d: ok=%0d waited %0d want %0d", k, ok, c, req);
      end
      cyc();
      if (k <= 15) begin eo = 4'(k); ed = 1'b1; ew = 1'b0; end
      else if (k <= 30) begin eo = 4'(30 - k); ed = 1'b0; ew = (k == 16); end
      else begin eo = 4'd1; ed = 1'b1; ew = 1'b1; end
      checks++;
      if ({o_out, o_dir, o_wrap} !== {eo, ed, ew}) begin
        errors++;
        $display("FAIL bounce_step %0d: out=%0d dir=%b wrap=%b want out=%0d dir=%b wrap=%b",
                 k, o_out, o_dir, o_wrap, eo, ed, ew);
      end
    end
  endtask

  task automatic test_up_wrap();
    bit ok; int c;
    int exp_seq [6] = '{6, 3, 4, 5, 6, 3};
    mode = 2'b00; lo = 4'd3; hi = 4'd6; load_val = 4'd5; load = 1'b1;
    cyc();
    load = 1'b0;
    checks++; if ({o_out, o_wrap} !== {4'd5, 1'b0}) begin errors++; $display("FAIL up_load: out=%0d wrap=%b want 5 0", o_out, o_wrap); end
    for (int i = 0; i < 6; i++) begin
      wait_tick(ok, c);
      checks++; if (!ok) begin errors++; $display("FAIL up_tick_timeout: step %0d waited %0d", i, c); end
      cyc();
      checks++;
      if ({o_out, o_wrap, o_dir} !== {4'(exp_seq[i]), (exp_seq[i] == 3), 1'b1}) begin
        errors++;
        $display("FAIL up_step %0d: out=%0d wrap=%b dir=%b want out=%0d wrap=%0d dir=1",
                 i, o_out, o_wrap, o_dir, exp_seq[i], (exp_seq[i] == 3));
      end
    end
  endtask

  task automatic test_down_wrap();
    bit ok; int c;
    int exp_seq [3] = '{9, 8, 7};
    mode = 2'b01; lo = 4'd2; hi = 4'd9; load_val = 4'd12; load = 1'b1;
    cyc();
    load = 1'b0;
    checks++; if (o_out !== 4'd12) begin errors++; $display("FAIL down_load: out=%0d want 12", o_out); end
    for (int i = 0; i < 3; i++) begin
      wait_tick(ok, c);
      checks++; if (!ok) begin errors++; $display("FAIL down_tick_timeout: step %0d waited %0d", i, c); end
      cyc();
      checks++;
      if ({o_out, o_wrap, o_dir} !== {4'(exp_seq[i]), (i == 0), 1'b0}) begin
        errors++;
        $display("FAIL down_step %0d: out=%0d wrap=%b dir=%b want out=%0d wrap=%0d dir=0",
                 i, o_out, o_wrap, o_dir, exp_seq[i], (i == 0));
      end
    end
  endtask

  task automatic test_speed_toggle();
    bit ok; int c;
    logic [W-1:0] held;
    mode = 2'b11;
    held = o_out;
    wait_tick(ok, c);
    checks++; if (!ok) begin errors++; $display("FAIL speed_sync_timeout: waited %0d", c); end
    // Switch to fast just before the slow tick would have fired.
    repeat (3) cyc();
    speed = 1'b1;
    cyc();
    checks++; if (o_tick !== 1'b0) begin errors++; $display("FAIL speed_up_suppress: tick=%b want 0", o_tick); end
    wait_tick(ok, c);
    checks++; if (!ok || c != 2) begin errors++; $display("FAIL speed_fast_first: waited %0d want 2", c); end
    cyc();
    wait_tick(ok, c);
    checks++; if (!ok || c != 1) begin errors++; $display("FAIL speed_fast_spacing: waited %0d want 1", c); end
    speed = 1'b0;
    cyc();
    checks++; if (o_tick !== 1'b0) begin errors++; $display("FAIL speed_down_suppress: tick=%b want 0", o_tick); end
    wait_tick(ok, c);
    checks++; if (!ok || c != 4) begin errors++; $display("FAIL speed_slow_first: waited %0d want 4", c); end
    cyc();
    wait_tick(ok, c);
    checks++; if (!ok || c != 3) begin errors++; $display("FAIL speed_slow_spacing: waited %0d want 3", c); end
    cyc();
    checks++; if ({o_out, o_wrap} !== {held, 1'b0}) begin errors++; $display("FAIL hold_mode: out=%0d wrap=%b want %0d 0", o_out, o_wrap, held); end
  endtask

  task automatic test_load_vs_tick();
    bit ok; int c;
    mode = 2'b00; lo = 4'd0; hi = 4'd15; load_val = 4'd2; load = 1'b1;
    cyc();
    load = 1'b0;
    checks++; if (o_out !== 4'd2) begin errors++; $display("FAIL load_pre: out=%0d want 2", o_out); end
    wait_tick(ok, c);
    checks++; if (!ok) begin errors++; $display("FAIL load_tick_timeout: waited %0d", c); end
    // Load lands in the same cycle as the tick; the step must be discarded.
    load_val = 4'd7; load = 1'b1;
    cyc();
    load = 1'b0;
    checks++; if ({o_out, o_wrap} !== {4'd7, 1'b0}) begin errors++; $display("FAIL load_tick_same: out=%0d wrap=%b want 7 0", o_out, o_wrap); end
    wait_tick(ok, c);
    cyc();
    checks++; if (!ok || o_out !== 4'd8) begin errors++; $display("FAIL load_then_step: out=%0d want 8", o_out); end
  endtask

  task automatic test_reset_in_bounce();
    bit ok; int c;
    int exp_seq [4] = '{14, 13, 12, 11};
    mode = 2'b10; lo = 4'd0; hi = 4'd15; load_val = 4'd15; load = 1'b1;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_tick(ok, c);
      cyc();
      checks++;
      if (!ok || {o_out, o_dir, o_wrap} !== {4'(exp_seq[i]), 1'b0, (i == 0)}) begin
        errors++;
        $display("FAIL rstb_step %0d: out=%0d dir=%b wrap=%b want out=%0d dir=0 wrap=%0d",
                 i, o_out, o_dir, o_wrap, exp_seq[i], (i == 0));
      end
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if ({o_out, o_dir, o_tick, o_wrap} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rstb_reset: out=%0d dir=%b tick=%b wrap=%b want 0 1 0 0", o_out, o_dir, o_tick, o_wrap);
    end
  endtask

  task automatic test_cfg_err();
    bit ok; int c; bit any_wrap;
    logic [W-1:0] held;
    mode = 2'b00; lo = 4'd8; hi = 4'd4;
    #1;
    checks++; if (o_cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_flag: got %b want 1", o_cfg_err); end
    held = o_out;
    any_wrap = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_tick(ok, c);
      cyc();
      if (o_wrap) any_wrap = 1'b1;
      checks++;
      if (!ok || o_out !== held) begin errors++; $display("FAIL cfg_err_hold %0d: out=%0d want %0d", i, o_out, held); end
    end
    checks++; if (any_wrap !== 1'b0) begin errors++; $display("FAIL cfg_err_wrap: saw wrap=1 want none"); end
    load_val = 4'd3; load = 1'b1;
    cyc();
    load = 1'b0;
    checks++; if (o_out !== 4'd3) begin errors++; $display("FAIL cfg_err_load: out=%0d want 3", o_out); end
  endtask

  task automatic test_lo_eq_hi();
    bit ok; int c;
    lo = 4'd5; hi = 4'd5;
    #1;
    checks++; if (o_cfg_err !== 1'b0) begin errors++; $display("FAIL eq_cfg_err: got %b want 0", o_cfg_err); end
    // dir was 1 before and must stay 1 in every mode, including down-wrap.
    for (int m = 0; m < 3; m++) begin
      mode = 2'(m);
      for (int i = 0; i < 2; i++) begin
        wait_tick(ok, c);
        cyc();
        checks++;
        if (!ok || {o_out, o_wrap, o_dir} !== {4'd5, 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL eq_step mode %0d step %0d: out=%0d wrap=%b dir=%b want 5 0 1", m, i, o_out, o_wrap, o_dir);
        end
      end
    end
  endtask

  task automatic test_enable();
    bit any_tick;
    logic [W-1:0] held;
    mode = 2'b00; lo = 4'd0; hi = 4'd15; en = 1'b0;
    cyc();
    held = o_out;
    any_tick = 1'b0;
    repeat (12) begin
      cyc();
      if (o_tick) any_tick = 1'b1;
    end
    checks++; if ({any_tick, o_out} !== {1'b0, held}) begin errors++; $display("FAIL en_freeze: tick_seen=%b out=%0d want 0 %0d", any_tick, o_out, held); end
    load_val = 4'd9; load = 1'b1;
    cyc();
    load = 1'b0;
    checks++; if (o_out !== 4'd9) begin errors++; $display("FAIL en_load: out=%0d want 9", o_out); end
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_up_wrap();
    test_down_wrap();
    test_speed_toggle();
    test_load_vs_tick();
    test_reset_in_bounce();
    test_cfg_err();
    test_lo_eq_hi();
    test_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_updown_counter_gen
